// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access stage and data memory.
// master drives req/we/be/addr/wdata; slave returns ack and rdata.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_W/8-1:0]   dmem_be;
  logic [ADDR_W-1:0]     dmem_addr;
  logic [DATA_W-1:0]     dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_W-1:0]     dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_be,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_be,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access stage: loads/stores with lane enables, extension,
// misalign/illegal checks, req/ack bus with timeout; ALU ops pass through.
// Ports: clk/rst_n, upstream in_valid/in_ready + ls/size/addr/store/wb
// fields, registered writeback out_valid/wb_*/exc_o, dmem bus interface.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ls_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              out_valid,
  output logic              wb_we_o,
  output logic [4:0]        wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [1:0]        exc_o,
  mem_access_unit_if.master dmem
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MIS  = 2'b01;
  localparam logic [1:0] EXC_TMO  = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                st_q, st_d;
  logic [2:0]          size_q, size_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic                lwe_q, lwe_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   baddr_q, baddr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                ov_q, ov_d;
  logic                wbwe_q, wbwe_d;
  logic [4:0]          wba_q, wba_d;
  logic [DATA_W-1:0]   wbd_q, wbd_d;
  logic [1:0]          exc_q, exc_d;

  // Accept-time decode
  logic              is_ld, is_st, illegal, mis;
  logic [7:0]        mask8;
  logic [BE_W-1:0]   be_n;
  logic [DATA_W-1:0] wdat_n;

  always_comb begin
    is_ld   = (ls_i == 2'b01);
    is_st   = (ls_i == 2'b10);
    illegal = (size_i == 3'b111)
            | (is_st & size_i[2])
            | ((DATA_W == 32) &
               ((size_i == 3'b011) | (size_i == 3'b110)));
    mis     = 1'b0;
    mask8   = 8'h01;
    wdat_n  = {BE_W{store_data_i[7:0]}};
    case (size_i[1:0])
      2'd1: begin
        mis    = addr_i[0];
        mask8  = 8'h03;
        wdat_n = {(BE_W/2){store_data_i[15:0]}};
      end
      2'd2: begin
        mis    = |addr_i[1:0];
        mask8  = 8'h0F;
        wdat_n = {(BE_W/4){store_data_i[31:0]}};
      end
      2'd3: begin
        mis    = |addr_i[2:0];
        mask8  = 8'hFF;
        wdat_n = store_data_i;
      end
      default: ;
    endcase
    // Aligned accesses never shift bits out of the 8-bit mask.
    be_n = BE_W'(mask8 << addr_i[OFF_W-1:0]);
  end

  // Load data alignment and extension
  logic [DATA_W-1:0] sh, keep, ld;
  logic              sb;

  always_comb begin
    sh   = dmem.dmem_rdata >> {off_q, 3'b000};
    sb   = sh[DATA_W-1];
    keep = '1;
    case (size_q[1:0])
      2'd0: begin sb = sh[7];  keep = DATA_W'(8'hFF);  end
      2'd1: begin sb = sh[15]; keep = DATA_W'(16'hFFFF); end
      2'd2: begin sb = sh[31]; keep = DATA_W'(32'hFFFF_FFFF); end
      default: ;
    endcase
    // size[2] marks the unsigned variants.
    ld = (sh & keep) | ({DATA_W{~size_q[2] & sb}} & ~keep);
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    size_d  = size_q;
    off_d   = off_q;
    lwe_d   = lwe_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    baddr_d = baddr_q;
    wdat_d  = wdat_q;
    ov_d    = 1'b0;
    wbwe_d  = wbwe_q;
    wba_d   = wba_q;
    wbd_d   = wbd_q;
    exc_d   = exc_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d   = is_st;
          size_d = size_i;
          off_d  = addr_i[OFF_W-1:0];
          lwe_d  = wb_we_i;
          wba_d  = wb_addr_i;
          wbd_d  = wb_data_i;
          wbwe_d = 1'b0;
          exc_d  = EXC_NONE;
          if (!(is_ld | is_st)) begin
            state_d = DONE;
            ov_d    = 1'b1;
            wbwe_d  = wb_we_i;
          end else if (illegal) begin
            state_d = DONE;
            ov_d    = 1'b1;
            exc_d   = EXC_ILL;
          end else if (mis) begin
            state_d = DONE;
            ov_d    = 1'b1;
            exc_d   = EXC_MIS;
          end else begin
            state_d = BUS;
            cnt_d   = '0;
            be_d    = be_n;
            baddr_d = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdat_d  = wdat_n;
          end
        end
      end
      BUS: begin
        // Ack beats a coincident timeout.
        if (dmem.dmem_ack) begin
          state_d = DONE;
          ov_d    = 1'b1;
          cnt_d   = '0;
          if (!st_q) begin
            wbd_d  = ld;
            wbwe_d = lwe_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          ov_d    = 1'b1;
          cnt_d   = '0;
          exc_d   = EXC_TMO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      lwe_q   <= 1'b0;
      cnt_q   <= '0;
      be_q    <= '0;
      baddr_q <= '0;
      wdat_q  <= '0;
      ov_q    <= 1'b0;
      wbwe_q  <= 1'b0;
      wba_q   <= '0;
      wbd_q   <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      size_q  <= size_d;
      off_q   <= off_d;
      lwe_q   <= lwe_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      baddr_q <= baddr_d;
      wdat_q  <= wdat_d;
      ov_q    <= ov_d;
      wbwe_q  <= wbwe_d;
      wba_q   <= wba_d;
      wbd_q   <= wbd_d;
      exc_q   <= exc_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = ov_q;
  assign wb_we_o         = wbwe_q;
  assign wb_addr_o       = wba_q;
  assign wb_data_o       = wbd_q;
  assign exc_o           = exc_q;
  // req/we/be follow the async-reset state, so reset drops them at once.
  assign dmem.dmem_req   = (state_q == BUS);
  assign dmem.dmem_we    = (state_q == BUS) & st_q;
  assign dmem.dmem_be    = (state_q == BUS) ? be_q : '0;
  assign dmem.dmem_addr  = baddr_q;
  assign dmem.dmem_wdata = wdat_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_W=32, TIMEOUT=4).
// Drives at posedge+1, checks inline with hand-computed values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  ls_i = '0;
  logic [2:0]  size_i = '0;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic        out_valid;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic [1:0]  exc_o;

  int checks = 0;
  int errors = 0;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_access_unit #(
    .DATA_W(32), .ADDR_W(32), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ls_i(ls_i), .size_i(size_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .wb_we_i(wb_we_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .out_valid(out_valid), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .exc_o(exc_o), .dmem(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in IDLE; returns just after the accept edge.
  task automatic issue(input logic [1:0] ls, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    in_valid = 1'b1;
    ls_i = ls; size_i = sz; addr_i = a; store_data_i = sd;
    wb_we_i = we; wb_addr_i = wa; wb_data_i = wd;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, wb_we_o, bus.dmem_req, bus.dmem_we, bus.dmem_be,
         exc_o} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b %b %b %b %h %b expected all 0",
               out_valid, wb_we_o, bus.dmem_req, bus.dmem_we,
               bus.dmem_be, exc_o);
    end
    checks++;
    if ({wb_addr_o, wb_data_o, bus.dmem_addr, bus.dmem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h expected 0",
               wb_addr_o, wb_data_o, bus.dmem_addr, bus.dmem_wdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_passthrough();
    issue(2'b00, 3'b010, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    checks++;
    if ({out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o, bus.dmem_req}
        !== {1'b1, 1'b1, 5'd5, 32'h1234, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL alu_pass: got v%b we%b a%0d d%h e%b r%b expected v1 we1 a5 d1234 e00 r0",
               out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o, bus.dmem_req);
    end
    step();
    checks++;
    if ({out_valid, in_ready, bus.dmem_req} !== 3'b010) begin
      errors++;
      $display("FAIL alu_after: got v%b rdy%b r%b expected v0 rdy1 r0",
               out_valid, in_ready, bus.dmem_req);
    end
  endtask

  task automatic test_load_byte(input logic [2:0] sz,
                                input logic [31:0] exp);
    issue(2'b01, sz, 32'h103, 32'h0, 1'b1, 5'd9, 32'h0);
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be}
        !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
      errors++;
      $display("FAIL lb_bus: got r%b w%b a%h be%b expected r1 w0 a100 be1000",
               bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be);
    end
    step();
    step();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h80FF_00AA;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if ({out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o}
        !== {1'b1, 1'b1, 5'd9, exp, 2'b00}) begin
      errors++;
      $display("FAIL lb_size%0d: got v%b we%b a%0d d%h e%b expected v1 we1 a9 d%h e00",
               sz, out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o, exp);
    end
    step();
  endtask

  task automatic test_load_half(input logic [2:0] sz,
                                input logic [31:0] exp);
    issue(2'b01, sz, 32'h6, 32'h0, 1'b1, 5'd2, 32'h0);
    checks++;
    if (bus.dmem_be !== 4'b1100 || bus.dmem_addr !== 32'h4) begin
      errors++;
      $display("FAIL lh_bus: got be%b a%h expected be1100 a4",
               bus.dmem_be, bus.dmem_addr);
    end
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h8001_7FFF;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || wb_data_o !== exp) begin
      errors++;
      $display("FAIL lh_size%0d: got v%b d%h expected v1 d%h",
               sz, out_valid, wb_data_o, exp);
    end
    step();
  endtask

  task automatic test_store_half();
    issue(2'b10, 3'b001, 32'h202, 32'hDEAD_BEEF, 1'b1, 5'd4, 32'h0);
    checks++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be,
         bus.dmem_wdata}
        !== {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++;
      $display("FAIL sh_bus: got r%b w%b a%h be%b wd%h expected r1 w1 a200 be1100 wdBEEFBEEF",
               bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be,
               bus.dmem_wdata);
    end
    step();
    checks++;
    if (bus.dmem_wdata !== 32'hBEEF_BEEF || bus.dmem_be !== 4'b1100) begin
      errors++;
      $display("FAIL sh_stable: got wd%h be%b expected wdBEEFBEEF be1100",
               bus.dmem_wdata, bus.dmem_be);
    end
    bus.dmem_ack = 1'b1;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if ({out_valid, wb_we_o, exc_o, bus.dmem_req} !== 5'b10000) begin
      errors++;
      $display("FAIL sh_done: got v%b we%b e%b r%b expected v1 we0 e00 r0",
               out_valid, wb_we_o, exc_o, bus.dmem_req);
    end
    step();
  endtask

  task automatic test_exceptions();
    issue(2'b01, 3'b010, 32'h101, 32'h0, 1'b1, 5'd1, 32'h0);
    checks++;
    if ({out_valid, wb_we_o, exc_o, bus.dmem_req} !== 5'b10010) begin
      errors++;
      $display("FAIL lw_misalign: got v%b we%b e%b r%b expected v1 we0 e01 r0",
               out_valid, wb_we_o, exc_o, bus.dmem_req);
    end
    step();
    issue(2'b01, 3'b111, 32'h101, 32'h0, 1'b1, 5'd1, 32'h0);
    checks++;
    if ({out_valid, wb_we_o, exc_o, bus.dmem_req} !== 5'b10110) begin
      errors++;
      $display("FAIL ill_over_mis: got v%b we%b e%b r%b expected v1 we0 e11 r0",
               out_valid, wb_we_o, exc_o, bus.dmem_req);
    end
    step();
    issue(2'b10, 3'b100, 32'h100, 32'h0, 1'b0, 5'd0, 32'h0);
    checks++;
    if (exc_o !== 2'b11 || bus.dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL store_bu: got e%b r%b expected e11 r0",
               exc_o, bus.dmem_req);
    end
    step();
    issue(2'b01, 3'b011, 32'h100, 32'h0, 1'b1, 5'd1, 32'h0);
    checks++;
    if (exc_o !== 2'b11 || wb_we_o !== 1'b0) begin
      errors++;
      $display("FAIL ld_on_32: got e%b we%b expected e11 we0",
               exc_o, wb_we_o);
    end
    step();
  endtask

  task automatic test_timeout();
    int n;
    issue(2'b01, 3'b010, 32'h300, 32'h0, 1'b1, 5'd7, 32'h0);
    n = 0;
    while (bus.dmem_req === 1'b1 && n < 10) begin
      n++;
      step();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL tmo_cycles: got %0d expected 4", n);
    end
    checks++;
    if ({out_valid, wb_we_o, exc_o} !== 4'b1010) begin
      errors++;
      $display("FAIL tmo_done: got v%b we%b e%b expected v1 we0 e10",
               out_valid, wb_we_o, exc_o);
    end
    step();
    issue(2'b01, 3'b010, 32'h300, 32'h0, 1'b1, 5'd7, 32'h0);
    step();
    step();
    step();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'h1122_3344;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if ({out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o}
        !== {1'b1, 1'b1, 5'd7, 32'h1122_3344, 2'b00}) begin
      errors++;
      $display("FAIL ack_at_tmo: got v%b we%b a%0d d%h e%b expected v1 we1 a7 d11223344 e00",
               out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o);
    end
    step();
  endtask

  task automatic test_stray_ack();
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stray_ack: got v%b rdy%b expected v0 rdy1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b11, 3'b000, 32'h0, 32'h0, 1'b1, 5'd10, 32'hAAAA_0001);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
        wb_data_o !== 32'hAAAA_0001) begin
      errors++;
      $display("FAIL b2b_first: got rdy%b v%b d%h expected rdy0 v1 dAAAA0001",
               in_ready, out_valid, wb_data_o);
    end
    step();
    issue(2'b00, 3'b000, 32'h0, 32'h0, 1'b0, 5'd11, 32'h5555_0002);
    checks++;
    if ({out_valid, wb_we_o, wb_addr_o, wb_data_o}
        !== {1'b1, 1'b0, 5'd11, 32'h5555_0002}) begin
      errors++;
      $display("FAIL b2b_second: got v%b we%b a%0d d%h expected v1 we0 a11 d55550002",
               out_valid, wb_we_o, wb_addr_o, wb_data_o);
    end
    step();
  endtask

  task automatic test_reset_in_bus();
    issue(2'b01, 3'b010, 32'h500, 32'h0, 1'b1, 5'd6, 32'h0);
    checks++;
    if (bus.dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rib_req: got %b expected 1", bus.dmem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.dmem_req !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rib_drop: got r%b v%b expected r0 v0",
               bus.dmem_req, out_valid);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rib_ready: got %b expected 1", in_ready);
    end
    issue(2'b01, 3'b010, 32'h400, 32'h0, 1'b1, 5'd3, 32'h0);
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hCAFE_BABE;
    step();
    bus.dmem_ack = 1'b0;
    checks++;
    if ({out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o}
        !== {1'b1, 1'b1, 5'd3, 32'hCAFE_BABE, 2'b00}) begin
      errors++;
      $display("FAIL rib_lw: got v%b we%b a%0d d%h e%b expected v1 we1 a3 dCAFEBABE e00",
               out_valid, wb_we_o, wb_addr_o, wb_data_o, exc_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_load_half(3'b001, 32'hFFFF_8001);
    test_load_half(3'b101, 32'h0000_8001);
    test_store_half();
    test_exceptions();
    test_timeout();
    test_stray_ack();
    test_back_to_back();
    test_reset_in_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the single-cycle MEM stage; sits between the execute stage and the register writeback.
- Adds a full load/store family: B/H/W/BU/HU, plus D/WU when DATA_W=64.
- Adds byte-lane enables with sign and zero extension, misalignment detection, and a variable-latency req/ack data-memory handshake with a timeout.
- Non-memory instructions pass through with one registered cycle of latency.

Parameters:
- DATA_W, 32: register and data-bus width; legal values are 32 or 64.
- ADDR_W, 32: byte-address width.
- TIMEOUT, 15: maximum number of cycles to wait for dmem_ack before reporting a bus fault; minimum 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  unit can accept an instruction; high only in IDLE.
- ls_i  in  2  access kind: 00 none, 01 load, 10 store, 11 treated as none.
- size_i  in  3  funct3 code: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- addr_i  in  ADDR_W  effective byte address.
- store_data_i  in  DATA_W  store source register value.
- wb_we_i  in  1  writeback enable.
- wb_addr_i  in  5  writeback register index.
- wb_data_i  in  DATA_W  ALU result.
- out_valid  out  1  one-cycle pulse marking a completed instruction.
- wb_we_o  out  1  writeback enable; qualified by out_valid.
- wb_addr_o  out  5  writeback register index.
- wb_data_o  out  DATA_W  writeback data.
- exc_o  out  2  exception code: 00 none, 01 misaligned, 10 bus timeout, 11 illegal size.
- dmem_req  out  1  memory request; held high until ack or timeout.
- dmem_we  out  1  1 = write.
- dmem_be  out  DATA_W/8  byte enables.
- dmem_addr  out  ADDR_W  bus-aligned address (low log2(DATA_W/8) bits zero).
- dmem_wdata  out  DATA_W  store data, lane-positioned.
- dmem_ack  in  1  memory completion; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  DATA_W  read data.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM goes to IDLE. out_valid, wb_we_o, dmem_req, dmem_we, dmem_be and the timeout counter clear to 0. wb_addr_o, wb_data_o, dmem_addr, dmem_wdata clear to 0. exc_o clears to 00.
- Reset mid-transaction: dmem_req drops immediately and the instruction is lost.
- FSM states: IDLE, BUS, DONE.
- Accept: an instruction is taken when in_valid && in_ready. In the same cycle, inputs are latched (ls, size, low address bits, wb_addr, wb_we, wb_data).
- Decode at accept:
  - ls=none: go to DONE. Outputs are the pass-through wb_*; exc_o=00. Latency 1 cycle.
  - Illegal size: 111, or 011/110 with DATA_W=32, or any size on a store other than 000/001/010/011. Go to DONE with exc_o=11, wb_we_o=0, and no bus request.
  - Misaligned access: H/HU with addr[0]≠0; W/WU with addr[1:0]≠0; D with addr[2:0]≠0. Go to DONE with exc_o=01, wb_we_o=0, and no request.
  - Otherwise: go to BUS.
- Priority: the illegal-size check takes precedence over the misalignment check.
- BUS state:
  - dmem_req=1 and dmem_we=(ls==store).
  - dmem_addr = addr with the low offset bits cleared.
  - dmem_be = size mask (B:1, H:3, W:0xF, D:0xFF) shifted left by the byte offset.
  - dmem_wdata = store_data low bytes replicated across all lanes.
  - All bus outputs stay stable until the state is left.
  - The counter increments each BUS cycle.
- On dmem_ack in BUS: go to DONE, clear the counter, drop dmem_req the next cycle.
  - Load: wb_data_o = dmem_rdata shifted right by 8×offset, then sign-extended (B/H/W) or zero-extended (BU/HU/WU) to DATA_W. wb_we_o = wb_we_i.
  - Store: wb_we_o=0.
- Timeout: if the counter reaches TIMEOUT with no ack, go to DONE with exc_o=10 and wb_we_o=0. If ack arrives in the same cycle as the timeout, ack wins and exc_o=00.
- DONE state: out_valid=1 for exactly one cycle, then IDLE. out_valid, wb_* and exc_o are registered outputs.
- dmem_ack outside BUS is ignored.
- Minimum latencies:
  - Back-to-back non-memory instructions: one every 2 cycles (accept, DONE).
  - Memory access: 2 + ack-wait cycles.

Test Plan:
- ALU pass-through: ls=00, wb_we=1, wb_addr=5, wb_data=0x1234 → next cycle out_valid=1, wb_data_o=0x1234, wb_addr_o=5, exc_o=00, dmem_req never asserted.
- Load signed byte: LB, addr=0x103, memory acks after 3 cycles with rdata=0x80FF_00AA → dmem_addr=0x100, dmem_be=4'b1000, wb_data_o=0xFFFF_FF80. Repeat with LBU → wb_data_o=0x0000_0080.
- Store half: SH, addr=0x202, store_data=0xDEAD_BEEF → dmem_we=1, dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, out_valid with wb_we_o=0.
- Misaligned access: LW with addr=0x101 → no dmem_req, exc_o=01, wb_we_o=0. Also LH with size=111 → exc_o=11, since illegal size wins.
- Timeout: TIMEOUT=4 with ack withheld → dmem_req high for 4 cycles then low, exc_o=10. Repeat with ack on the 4th cycle → exc_o=00 and data written back.
- Reset in BUS: assert rst_n=0 mid-request → dmem_req=0 immediately with no clock, out_valid=0. After release, in_ready=1 and the next LW completes normally.
